// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares the single sdram_ctrl port between the SPI flash
// emulator (spi_*) and the serial user parser (usr_*).
//   - SPI wins arbitration; a waiting user gets one grant after MAX_SPI_RUN
//     back-to-back SPI grants, but never while spi_critical is high.
//   - Turns the controller's level ack into 1-cycle spi_ack/usr_ack pulses
//     and latches read data into rd_data.
//   - Grants with no ack for ACK_TIMEOUT cycles are aborted and counted.
// Ports:
//   clk, reset (async, active-low)
//   spi_critical, spi_req, spi_addr            -> spi_ack
//   usr_req, usr_we, usr_addr, usr_wr_data,
//   usr_wr_mask                                -> usr_ack, usr_idle
//   crit_ready, rd_data, timeouts              status outputs
//   sd_enable, sd_we, sd_addr, sd_wr_data,
//   sd_wr_mask                                 to sdram_ctrl
//   sd_ack_level, sd_idle, sd_rd_data          from sdram_ctrl
// Build option: define ARB_STATS_EN to add the spi_grants/usr_grants
// completed-access counters.
module sdram_arbiter #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned MAX_SPI_RUN = 8,
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              spi_critical,
   input  logic              spi_req,
   input  logic [ADDR_W-1:0] spi_addr,
   output logic              spi_ack,
   input  logic              usr_req,
   input  logic              usr_we,
   input  logic [ADDR_W-1:0] usr_addr,
   input  logic [DATA_W-1:0] usr_wr_data,
   input  logic [1:0]        usr_wr_mask,
   output logic              usr_ack,
   output logic              usr_idle,
   output logic              crit_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic [7:0]        timeouts,
`ifdef ARB_STATS_EN
   output logic [15:0]       spi_grants,
   output logic [15:0]       usr_grants,
`endif
   output logic              sd_enable,
   output logic              sd_we,
   output logic [ADDR_W-1:0] sd_addr,
   output logic [DATA_W-1:0] sd_wr_data,
   output logic [1:0]        sd_wr_mask,
   input  logic              sd_ack_level,
   input  logic              sd_idle,
   input  logic [DATA_W-1:0] sd_rd_data
);

   localparam int unsigned RUN_W  = $clog2(MAX_SPI_RUN + 1);
   localparam int unsigned GCNT_W = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, GNT_SPI, GNT_USR, WAIT_REL} state_t;

   state_t             state;
   logic               usr_owner;   // current/last grant belongs to the user
   logic [RUN_W-1:0]   run;
   logic [GCNT_W-1:0]  gcnt;
   logic               arb_open;
   logic               grant_usr;
   logic               grant_spi;

   // Arbitration decision for this cycle; user only wins when SPI is idle
   // or the user has waited out MAX_SPI_RUN SPI grants.
   assign arb_open  = (state == IDLE) && !sd_ack_level && sd_idle;
   assign grant_usr = arb_open && usr_req && !spi_critical &&
                      (!spi_req || (run == RUN_W'(MAX_SPI_RUN)));
   assign grant_spi = arb_open && spi_req && !grant_usr;

   // Arbiter FSM with registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         usr_owner  <= 1'b0;
         run        <= '0;
         gcnt       <= '0;
         spi_ack    <= 1'b0;
         usr_ack    <= 1'b0;
         usr_idle   <= 1'b0;
         crit_ready <= 1'b0;
         rd_data    <= '0;
         timeouts   <= '0;
         sd_enable  <= 1'b0;
         sd_we      <= 1'b0;
         sd_addr    <= '0;
         sd_wr_data <= '0;
         sd_wr_mask <= '0;
`ifdef ARB_STATS_EN
         spi_grants <= '0;
         usr_grants <= '0;
`endif
      end else begin
         spi_ack    <= 1'b0;
         usr_ack    <= 1'b0;
         usr_idle   <= (state == IDLE) && sd_idle && !spi_critical;
         crit_ready <= spi_critical && !((state != IDLE) && usr_owner);

         // Starvation run length; saturates so a long critical window
         // cannot wrap it.
         if (!usr_req || grant_usr) begin
            run <= '0;
         end else if (grant_spi && (run != RUN_W'(MAX_SPI_RUN))) begin
            run <= run + RUN_W'(1);
         end

         case (state)
            IDLE: begin
               if (grant_usr) begin
                  state      <= GNT_USR;
                  usr_owner  <= 1'b1;
                  gcnt       <= '0;
                  sd_enable  <= 1'b1;
                  sd_we      <= usr_we;
                  sd_addr    <= usr_addr;
                  sd_wr_data <= usr_wr_data;
                  sd_wr_mask <= usr_wr_mask;
               end else if (grant_spi) begin
                  state      <= GNT_SPI;
                  usr_owner  <= 1'b0;
                  gcnt       <= '0;
                  sd_enable  <= 1'b1;
                  sd_we      <= 1'b0;
                  sd_addr    <= spi_addr;
                  sd_wr_data <= DATA_W'(16'hDEAD);
                  sd_wr_mask <= 2'b00;
               end
            end
            GNT_SPI, GNT_USR: begin
               if (sd_ack_level) begin
                  state     <= WAIT_REL;
                  sd_enable <= 1'b0;
                  if (state == GNT_SPI) begin
                     spi_ack <= 1'b1;
                     rd_data <= sd_rd_data;
`ifdef ARB_STATS_EN
                     spi_grants <= spi_grants + 16'd1;
`endif
                  end else begin
                     usr_ack <= 1'b1;
                     if (!sd_we) begin
                        rd_data <= sd_rd_data;
                     end
`ifdef ARB_STATS_EN
                     usr_grants <= usr_grants + 16'd1;
`endif
                  end
               end else if (gcnt == GCNT_W'(ACK_TIMEOUT - 1)) begin
                  // Abort without ack; requester stays pending and is re-arbitrated.
                  state     <= WAIT_REL;
                  sd_enable <= 1'b0;
                  if (timeouts != 8'hFF) begin
                     timeouts <= timeouts + 8'd1;
                  end
               end else begin
                  gcnt <= gcnt + GCNT_W'(1);
               end
            end
            WAIT_REL: begin
               if (!sd_ack_level) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
